// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and border-length helper for the sequence detector
package seq_det_pkg;

  localparam int PAT_W_MAX = 8;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;

  // p holds a w-bit pattern right-justified, MSB first; returns its longest proper border.
  function automatic int border_len(input logic [PAT_W_MAX-1:0] p, input int w);
    int best;
    logic [PAT_W_MAX-1:0] msk;
    best = 0;
    msk = '0;
    for (int j = 1; j < PAT_W_MAX; j++) begin
      msk = (PAT_W_MAX'(1) << j) - PAT_W_MAX'(1);
      if (j < w && (p >> (w - j)) == (p & msk)) best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// rtl/seq_det_next.sv - combinational KMP next-state for a runtime pattern
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  localparam int KW = $clog2(PAT_W)
) (
  input  logic [PAT_W-1:0] pat,
  input  logic [KW-1:0]    k,
  input  logic             y,
  input  logic             ovl,
  output logic [KW-1:0]    k_nxt,
  output logic             hit
);

  logic [PAT_W:0] s_vec;
  logic [PAT_W:0] pre;
  logic [PAT_W:0] msk;

  always_comb begin
    int kk;
    int best;
    int brd;
    s_vec = '0;
    pre   = '0;
    msk   = '0;
    hit   = 1'b0;
    k_nxt = '0;
    kk    = int'(k);
    // Matched prefix followed by the new bit, oldest bit in the MSB, new bit in the LSB.
    s_vec = (({1'b0, pat} >> (PAT_W - kk)) << 1) | {{PAT_W{1'b0}}, y};
    hit   = (kk == PAT_W - 1) && (y == pat[0]);
    best  = 0;
    for (int j = 1; j < PAT_W; j++) begin
      pre = {1'b0, pat} >> (PAT_W - j);
      msk = ((PAT_W+1)'(1) << j) - (PAT_W+1)'(1);
      if (j <= kk + 1 && (s_vec & msk) == pre) best = j;
    end
    brd = border_len(PAT_W_MAX'(pat), PAT_W);
    if (hit) k_nxt = ovl ? KW'(brd) : '0;
    else     k_nxt = KW'(best);
  end

endmodule

// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - serial pattern detector with loadable pattern and saturating match count
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y,
  input  logic             en,
  input  logic             ovl,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  output logic             z,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_sat
);

  localparam int KW = $clog2(PAT_W);

  logic [KW-1:0]    k;
  logic [KW-1:0]    k_nxt;
  logic [PAT_W-1:0] pat;
  logic             hit;
  logic [CNT_W-1:0] cnt_nxt;

  seq_det_next #(.PAT_W(PAT_W)) u_next (
    .pat   (pat),
    .k     (k),
    .y     (y),
    .ovl   (ovl),
    .k_nxt (k_nxt),
    .hit   (hit)
  );

  assign z       = en & rst & ~pat_ld & hit;
  assign cnt_nxt = (z && !(&cnt)) ? cnt + CNT_W'(1) : cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        k <= '0;
    else if (pat_ld) k <= '0;
    else if (en)     k <= k_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pat <= PATTERN;
    else if (pat_ld) pat <= pat_in;
  end

  // Sticky flag follows the count into all-ones on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      cnt_sat <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      cnt_sat <= cnt_sat | (&cnt_nxt);
    end
  end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits; legal range 2..8.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1101, meaning the reset-time pattern (PAT_W bits, MSB is the first bit received).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the match-counter width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port y, input, 1 bit: serial data bit, sampled when en=1.
REQ-007 Port en, input, 1 bit: bit-valid qualifier; en=0 means no bit this cycle.
REQ-008 Port ovl, input, 1 bit: mode select, 1=overlapping detection and 0=non-overlapping.
REQ-009 Port pat_ld, input, 1 bit: load a new pattern from pat_in on this edge.
REQ-010 Port pat_in, input, PAT_W bits: the new pattern value.
REQ-011 Port z, output, 1 bit: Mealy match pulse.
REQ-012 Port cnt, output, CNT_W bits: registered match count.
REQ-013 Port cnt_sat, output, 1 bit: the count has saturated.

Function
REQ-014 The state SHALL be the matched-prefix length k, range 0..PAT_W-1, held in a register of $clog2(PAT_W) bits.
REQ-015 z SHALL be combinational: z = en & rst & ~pat_ld & (k==PAT_W-1) & (y==pat[0]); detection latency is zero cycles from the last pattern bit.
REQ-016 On en=1 with no match, the next k SHALL be the longest j such that pattern prefix length j equals the suffix of (matched k bits followed by y); this is the KMP failure rule applied to the runtime pattern.
REQ-017 On a match with ovl=1, the next k SHALL be the longest proper border of the full pattern (1 for 1101).
REQ-018 On a match with ovl=0, the next k SHALL be 0.
REQ-019 ovl SHALL be sampled per bit and SHALL only affect the post-match transition.
REQ-020 With en=0, k, cnt and pat SHALL hold and z SHALL be 0.
REQ-021 When pat_ld=1, pat<=pat_in and k<=0 on that edge; the bit presented in that cycle SHALL be discarded, and z=0 and cnt holds.
REQ-022 When pat_ld=1 and en=1 occur together, the load SHALL win per REQ-021.
REQ-023 On each z=1 cycle, cnt SHALL increment by 1 at the edge, saturating at 2^CNT_W-1.
REQ-024 cnt_sat SHALL be registered and set when cnt reaches all-ones; it SHALL clear only on reset.
REQ-025 Next-state evaluation SHALL be pure combinational logic over pat and k, with no multicycle computation.

Reset
REQ-026 When rst=0, the block SHALL asynchronously set k=0, pat=PATTERN, cnt=0 and cnt_sat=0.
REQ-027 While rst=0, z SHALL be 0 regardless of y, en and pat_ld.
REQ-028 After rst is deasserted, the first en=1 bit SHALL be treated as pattern bit 1 with no stale partial match.
REQ-029 Reset mid-stream SHALL discard any partial match; the matched prefix SHALL not survive reset.

Structure
REQ-030 A package seq_det_pkg SHALL hold PAT_W_MAX=8, the default PATTERN, and a function that computes the border length of a PAT_W-bit vector.
REQ-031 The next-state logic SHALL be a combinational sub-module seq_det_next with inputs pat, k, y and ovl and outputs k_nxt and hit.
REQ-032 The top level SHALL contain only the registers (k, pat, cnt, cnt_sat), the en and pat_ld gating, and the z assignment.
REQ-033 The top level SHALL have a single always block per register group, and there SHALL be no latches.

Verification
REQ-034 Defaults, ovl=1, stream 1101101 with en=1 every cycle -> z=1 on bits 4 and 7; cnt=2.
REQ-035 Defaults, ovl=0, stream 1101101 -> z=1 on bit 4 only; cnt=1.
REQ-036 Stream 11011 with en=0 bubbles inserted between every bit -> z=1 only in the cycle carrying bit 4; state held across bubbles.
REQ-037 After bits 110, pat_ld=1 with pat_in=4'b0110 while y=1 -> k=0 and z=0 in that cycle; then stream 0110 -> z=1 on its last bit.
REQ-038 CNT_W=2, ovl=1, stream 1101101101101 (4 matches) -> cnt=3 after the 3rd match; cnt_sat=1; cnt stays 3 after the 4th match.
REQ-039 Reset pulse after bits 110, then stream 1 -> no z; stream 1101 -> z=1 on its 4th bit.
